imm_encoder: RTL and testbench

//  Inverse of the immediate decoder. Packs instruction fields and a full-width

---
 rtl/imm_encoder_if.sv | 36 +++
 rtl/imm_encoder.sv | 172 +++++++++++++++++
 tb/tb_imm_encoder.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_encoder_if.sv
// Handshake bundle between the instruction encoder and its source/sink.
// The encoder is the slave; the generator/sink side is the master.
interface imm_encoder_if #(
  parameter int XLEN   = 32,
  parameter int OP_LEN = 7,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        types;
  logic [OP_LEN-1:0] opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [XLEN-1:0]   imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       instr;
  logic [2:0]        err;
  logic [CNT_W-1:0]  err_cnt;
  logic              clr_cnt;

  modport slave (
    input  in_valid, types, opcode, funct3, funct7, rd, rs1, rs2, imm,
    input  out_ready, clr_cnt,
    output in_ready, out_valid, instr, err, err_cnt
  );

  modport master (
    output in_valid, types, opcode, funct3, funct7, rd, rs1, rs2, imm,
    output out_ready, clr_cnt,
    input  in_ready, out_valid, instr, err, err_cnt
  );
endinterface

// File: rtl/imm_encoder.sv
// Packs RV32 fields plus a full-width immediate into an instruction word and flags unencodable immediates.
// Two-stage pipe, 2-cycle latency; stalls hold the output word, input refused only when both stages are full and the sink stalls.
module imm_encoder #(
  parameter int XLEN   = 32,
  parameter int OP_LEN = 7,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          rst_n,
  imm_encoder_if.slave bus
);
  localparam logic [6:0] T_R    = 7'b1000000;
  localparam logic [6:0] T_I    = 7'b0100000;
  localparam logic [6:0] T_L    = 7'b0010000;
  localparam logic [6:0] T_S    = 7'b0001000;
  localparam logic [6:0] T_J    = 7'b0000100;
  localparam logic [6:0] T_B    = 7'b0000010;
  localparam logic [6:0] T_U    = 7'b0000001;
  localparam logic [6:0] T_JALR = 7'b0100100;

  logic              s1_vld_q;
  logic [6:0]        s1_types_q;
  logic [OP_LEN-1:0] s1_op_q;
  logic [2:0]        s1_f3_q;
  logic [6:0]        s1_f7_q;
  logic [4:0]        s1_rd_q;
  logic [4:0]        s1_rs1_q;
  logic [4:0]        s1_rs2_q;
  logic [XLEN-1:0]   s1_imm_q;
  logic [2:0]        s1_err_q;

  logic              s2_vld_q;
  logic [31:0]       s2_instr_q;
  logic [2:0]        s2_err_q;

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic              s1_adv;
  logic              s2_adv;
  logic              eq11;
  logic              eq12;
  logic              eq20;
  logic              type_e;
  logic              align_e;
  logic              range_e;
  logic              s1_shift;
  logic [31:0]       instr_d;

  // A stage may load when it is empty or its content moves on this cycle.
  assign s2_adv       = !s2_vld_q || bus.out_ready;
  assign s1_adv       = !s1_vld_q || s2_adv;
  assign bus.in_ready = s1_adv;

  // Sign-extension checks: the upper bits must all be copies of the top kept bit.
  assign eq11 = (&bus.imm[31:11]) || !(|bus.imm[31:11]);
  assign eq12 = (&bus.imm[31:12]) || !(|bus.imm[31:12]);
  assign eq20 = (&bus.imm[31:20]) || !(|bus.imm[31:20]);

  always_comb begin
    type_e  = 1'b0;
    align_e = 1'b0;
    range_e = 1'b0;
    case (bus.types)
      T_R: ;
      T_I: begin
        if (bus.funct3[1:0] == 2'b01) range_e = |bus.imm[31:5];
        else                          range_e = !eq11;
      end
      T_L, T_JALR, T_S: range_e = !eq11;
      T_B: begin
        range_e = !eq12;
        align_e = bus.imm[0];
      end
      T_J: begin
        range_e = !eq20;
        align_e = bus.imm[0];
      end
      T_U:     align_e = |bus.imm[11:0];
      default: type_e  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_types_q <= '0;
      s1_op_q    <= '0;
      s1_f3_q    <= '0;
      s1_f7_q    <= '0;
      s1_rd_q    <= '0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_imm_q   <= '0;
      s1_err_q   <= '0;
    end else if (s1_adv) begin
      s1_vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_types_q <= bus.types;
        s1_op_q    <= bus.opcode;
        s1_f3_q    <= bus.funct3;
        s1_f7_q    <= bus.funct7;
        s1_rd_q    <= bus.rd;
        s1_rs1_q   <= bus.rs1;
        s1_rs2_q   <= bus.rs2;
        s1_imm_q   <= bus.imm;
        s1_err_q   <= {type_e, align_e, range_e};
      end
    end
  end

  assign s1_shift = (s1_types_q == T_I) && (s1_f3_q[1:0] == 2'b01);

  // Range/align errors still pack the truncated bits; only an unknown type yields zero.
  always_comb begin
    instr_d = '0;
    case (s1_types_q)
      T_R: instr_d = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      T_I: begin
        if (s1_shift)
          instr_d = {s1_f7_q, s1_imm_q[4:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
        else
          instr_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      end
      T_L, T_JALR:
        instr_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      T_S:
        instr_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0], s1_op_q};
      T_B:
        instr_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                   s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
      T_J:
        instr_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                   s1_rd_q, s1_op_q};
      T_U:     instr_d = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
      default: instr_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q   <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= '0;
    end else if (s2_adv) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_instr_q <= instr_d;
        s2_err_q   <= s1_err_q;
      end
    end
  end

  // Clear has priority over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr_cnt)
      cnt_d = '0;
    else if (s2_vld_q && bus.out_ready && (|s2_err_q) && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.out_valid = s2_vld_q;
  assign bus.instr     = s2_instr_q;
  assign bus.err       = s2_err_q;
  assign bus.err_cnt   = cnt_q;
endmodule

// File: tb/tb_imm_encoder.sv
// Randomized and directed bench for imm_encoder against an arithmetic reference encoder and an RV32 decoder.
module tb_imm_encoder;
  localparam logic [6:0] TR  = 7'h40;
  localparam logic [6:0] TI  = 7'h20;
  localparam logic [6:0] TL  = 7'h10;
  localparam logic [6:0] TS  = 7'h08;
  localparam logic [6:0] TJ  = 7'h04;
  localparam logic [6:0] TB  = 7'h02;
  localparam logic [6:0] TU  = 7'h01;
  localparam logic [6:0] TJR = 7'h24;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  err;
    int          cyc;
    logic [6:0]  types;
    logic [2:0]  f3;
    logic [31:0] imm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_encoder_if bus ();
  imm_encoder_if #(.CNT_W(2)) bus2 ();

  imm_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  imm_encoder #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          ord_mode = 0;
  int          cnt_m = 0;
  bit          acc;
  bit          chk_lat = 0;
  bit          use_lit = 0;
  logic [31:0] lit_i;
  logic [2:0]  lit_e;
  bit          hold_vld = 0;
  logic [31:0] hold_instr;
  logic [2:0]  hold_err;
  exp_t        sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  function automatic bit fits(input logic [31:0] v, input int n);
    longint s;
    longint lim;
    s   = longint'($signed(v));
    lim = longint'(1) << (n - 1);
    return (s >= -lim) && (s < lim);
  endfunction

  // Reference encoder: field placement by shift/mask, range by signed bounds.
  function automatic logic [34:0] model(input logic [6:0] t, input logic [6:0] op,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w;
    logic [31:0] base_i;
    logic [31:0] base_s;
    logic ty, al, rg;
    w = '0; ty = 1'b0; al = 1'b0; rg = 1'b0;
    base_i = (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
    base_s = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    case (t)
      TR: w = (32'(f7) << 25) | (32'(rs2) << 20) | base_i;
      TI, TL, TJR: begin
        if (t == TI && (f3 & 3'd3) == 3'd1) begin
          w  = (32'(f7) << 25) | (fld(imm, 4, 0) << 20) | base_i;
          rg = imm > 32'd31;
        end else begin
          w  = (fld(imm, 11, 0) << 20) | base_i;
          rg = !fits(imm, 12);
        end
      end
      TS: begin
        w  = (fld(imm, 11, 5) << 25) | base_s | (fld(imm, 4, 0) << 7);
        rg = !fits(imm, 12);
      end
      TB: begin
        w  = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | base_s
           | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7);
        rg = !fits(imm, 13);
        al = (imm % 2) != 0;
      end
      TJ: begin
        w  = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20)
           | (fld(imm, 19, 12) << 12) | (32'(rd) << 7) | 32'(op);
        rg = !fits(imm, 21);
        al = (imm % 2) != 0;
      end
      TU: begin
        w  = (fld(imm, 31, 12) << 12) | (32'(rd) << 7) | 32'(op);
        al = (imm % 4096) != 0;
      end
      default: ty = 1'b1;
    endcase
    return {ty, al, rg, w};
  endfunction

  function automatic logic [31:0] decode(input logic [31:0] w, input logic [6:0] t, input logic [2:0] f3);
    logic [31:0] r;
    r = '0;
    case (t)
      TI: r = (f3[1:0] == 2'b01) ? {27'd0, w[24:20]} : {{20{w[31]}}, w[31:20]};
      TL, TJR: r = {{20{w[31]}}, w[31:20]};
      TS: r = {{20{w[31]}}, w[31:25], w[11:7]};
      TB: r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      TJ: r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      TU: r = {w[31:12], 12'd0};
      default: r = '0;
    endcase
    return r;
  endfunction

  // One clock: entered at a negedge, checks the handshakes of the coming posedge.
  task automatic step();
    exp_t e;
    logic [34:0] m;
    case (ord_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = (cyc % 2) == 0;
      2: bus.out_ready = ($urandom_range(0, 3) != 0);
      3: bus.out_ready = 1'b0;
      default: ;
    endcase
    #1;
    chk("in_ready", bus.in_ready, !(sb.size() >= 2 && !bus.out_ready));
    chk("err_cnt", bus.err_cnt, cnt_m);
    if (hold_vld) begin
      chk("hold_vld", bus.out_valid, 1);
      chk("hold_instr", bus.instr, hold_instr);
      chk("hold_err", bus.err, hold_err);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("instr", bus.instr, e.instr);
        chk("err", bus.err, e.err);
        if (chk_lat) chk("latency", cyc - e.cyc, 2);
        if (e.err == 3'b000 && e.types != TR)
          chk("roundtrip", decode(bus.instr, e.types, e.f3), e.imm);
        if (e.err != 3'b000 && cnt_m < 65535) cnt_m++;
      end
    end
    if (bus.clr_cnt) cnt_m = 0;
    hold_vld   = bus.out_valid && !bus.out_ready;
    hold_instr = bus.instr;
    hold_err   = bus.err;
    if (bus.in_valid && bus.in_ready) begin
      acc = 1'b1;
      m = model(bus.types, bus.opcode, bus.funct3, bus.funct7, bus.rd, bus.rs1, bus.rs2, bus.imm);
      e.instr = use_lit ? lit_i : m[31:0];
      e.err   = use_lit ? lit_e : m[34:32];
      e.cyc   = cyc;
      e.types = bus.types;
      e.f3    = bus.funct3;
      e.imm   = bus.imm;
      sb.push_back(e);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [6:0] t, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm,
                      input bit lit, input logic [31:0] li, input logic [2:0] le);
    bus.types = t; bus.opcode = op; bus.funct3 = f3; bus.funct7 = f7;
    bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm;
    use_lit = lit; lit_i = li; lit_e = le;
    bus.in_valid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 200 && !acc; n++) step();
    if (!acc) chk("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
    use_lit = 1'b0;
  endtask

  task automatic send_rand();
    logic [6:0] t;
    logic [2:0] f3;
    logic [31:0] imm;
    case ($urandom_range(0, 7))
      0: t = TR;  1: t = TI;  2: t = TL;  3: t = TS;
      4: t = TJ;  5: t = TB;  6: t = TU;  default: t = TJR;
    endcase
    f3 = 3'($urandom());
    case (t)
      TI, TL, TJR, TS: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      TB: imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
      TJ: imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
      TU: imm = $urandom() & 32'hFFFFF000;
      default: imm = $urandom();
    endcase
    if (t == TI && (f3 & 3'd3) == 3'd1) imm = 32'($urandom_range(0, 31));
    if ($urandom_range(0, 15) == 0) imm = $urandom();
    if ($urandom_range(0, 31) == 0) t = 7'($urandom());
    send(t, 7'($urandom()), f3, 7'($urandom()), 5'($urandom()), 5'($urandom()),
         5'($urandom()), imm, 1'b0, 32'd0, 3'd0);
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && sb.size() != 0; n++) step();
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    bus.in_valid = 0; bus.types = 0; bus.opcode = 0; bus.funct3 = 0; bus.funct7 = 0;
    bus.rd = 0; bus.rs1 = 0; bus.rs2 = 0; bus.imm = 0; bus.out_ready = 0; bus.clr_cnt = 0;
    bus2.in_valid = 0; bus2.types = 0; bus2.opcode = 0; bus2.funct3 = 0; bus2.funct7 = 0;
    bus2.rd = 0; bus2.rs1 = 0; bus2.rs2 = 0; bus2.imm = 0; bus2.out_ready = 1; bus2.clr_cnt = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // addi x1, x2, -2048 with latency check
    chk_lat = 1'b1;
    send(TI, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFFF800, 1'b1, 32'h80010093, 3'b000);
    drain();
    chk_lat = 1'b0;

    send(TB, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'h00000FFE, 1'b1, 32'h7E208FE3, 3'b000);
    send(TB, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'h00001001, 1'b1, 32'h80208063, 3'b011);
    send(TJ, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h00100000, 1'b1, 32'h8000006F, 3'b001);
    send(TJ, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFF00000, 1'b1, 32'h8000006F, 3'b000);
    drain();

    ord_mode = 1;
    for (int i = 0; i < 8; i++) send_rand();
    drain();
    ord_mode = 0;

    bus.clr_cnt = 1'b1;
    step();
    bus.clr_cnt = 1'b0;
    for (int i = 0; i < 3; i++)
      send(7'h00, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, 32'd0, 3'b100);
    drain();
    #1;
    chk("cnt_three", bus.err_cnt, 3);
    @(negedge clk);
    ord_mode = 3;
    send(7'h00, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, 32'd0, 3'b100);
    for (int n = 0; n < 20 && !bus.out_valid; n++) step();
    ord_mode = 4;
    bus.out_ready = 1'b1;
    bus.clr_cnt   = 1'b1;
    step();
    bus.clr_cnt = 1'b0;
    #1;
    chk("cnt_clr_wins", bus.err_cnt, 0);
    @(negedge clk);
    ord_mode = 0;

    bus2.types = 7'h00;
    bus2.in_valid = 1'b1;
    repeat (5) @(negedge clk);
    bus2.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("cnt_saturate", bus2.err_cnt, 3);
    @(negedge clk);

    // reset with a full pipe and a nonzero counter
    send(7'h00, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, 32'd0, 3'b100);
    send(7'h00, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, 32'd0, 3'b100);
    drain();
    ord_mode = 3;
    send(TU, 7'h37, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'h12345000, 1'b0, 32'd0, 3'd0);
    send(TU, 7'h37, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'hABCDE000, 1'b0, 32'd0, 3'd0);
    for (int n = 0; n < 20 && !bus.out_valid; n++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_instr", bus.instr, 0);
    chk("mid_rst_err", bus.err, 0);
    chk("mid_rst_err_cnt", bus.err_cnt, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    sb.delete();
    cnt_m = 0;
    hold_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    ord_mode = 2;
    for (int i = 0; i < 10000; i++) send_rand();
    ord_mode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
